// File: rtl/pc_unit_if.sv
// Next-PC control and status bundle between the sequencer and pc_unit.
// Sequencer drives selects and targets; pc_unit returns PC, stack depth and sticky flags.
interface pc_unit_if;
   logic [2:0]  pc_ctrl;
   logic        pc_increment;
   logic        is_call;
   logic [15:0] jump_target;
   logic [15:0] branch_offset;
   logic [15:0] loop_target;
   logic        clear_err;
   logic [15:0] pc;
   logic [15:0] pc_plus1;
   logic        pc_updated;
   logic [3:0]  ras_depth;
   logic        ras_ovf;
   logic        ras_unf;
   logic        ctrl_err;

   modport master (
      output pc_ctrl, pc_increment, is_call, jump_target, branch_offset, loop_target, clear_err,
      input  pc, pc_plus1, pc_updated, ras_depth, ras_ovf, ras_unf, ctrl_err
   );

   modport slave (
      input  pc_ctrl, pc_increment, is_call, jump_target, branch_offset, loop_target, clear_err,
      output pc, pc_plus1, pc_updated, ras_depth, ras_ovf, ras_unf, ctrl_err
   );
endinterface

// File: rtl/pc_unit.sv
// Program counter with circular return-address stack; new PC visible the cycle after a commit.
// No backpressure: every edge with pc_increment high commits, otherwise all state holds.
module pc_unit #(
   parameter logic [15:0] RESET_VECTOR = 16'h0000,
   parameter int          RAS_DEPTH    = 4
) (
   input  logic     clk,
   input  logic     rst_n,
   pc_unit_if.slave bus
);
   localparam int         PTR_W     = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
   localparam logic [3:0] DEPTH_MAX = 4'(RAS_DEPTH);

   logic [15:0]      pc_q;
   logic [15:0]      pc_nxt;
   logic [15:0]      pc_inc;
   logic [15:0]      ras_top;
   logic [15:0]      ras_mem [RAS_DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] top_ptr;
   logic [3:0]       depth_q;
   logic             upd_q;
   logic             ovf_q;
   logic             unf_q;
   logic             cerr_q;
   logic             ras_full;
   logic             ras_empty;
   logic             push;
   logic             pop;
   logic             ovf_evt;
   logic             unf_evt;
   logic             cerr_evt;

   assign pc_inc    = pc_q + 16'd1;
   assign ras_full  = (depth_q == DEPTH_MAX);
   assign ras_empty = (depth_q == 4'd0);
   // wr_ptr points at the next free slot; a push when full overwrites the oldest entry
   assign top_ptr   = wr_ptr - PTR_W'(1);
   assign ras_top   = ras_mem[top_ptr];

   always_comb begin
      pc_nxt   = pc_inc;
      push     = 1'b0;
      pop      = 1'b0;
      ovf_evt  = 1'b0;
      unf_evt  = 1'b0;
      cerr_evt = 1'b0;
      case (bus.pc_ctrl)
         3'b000: begin
            pc_nxt  = bus.jump_target;
            push    = bus.is_call;
            ovf_evt = bus.is_call & ras_full;
         end
         3'b001: pc_nxt = pc_q + bus.branch_offset;
         3'b010: begin
            if (ras_empty) begin
               unf_evt = 1'b1;
            end else begin
               pc_nxt = ras_top;
               pop    = 1'b1;
            end
         end
         3'b011: pc_nxt = pc_inc;
         3'b100: pc_nxt = bus.loop_target;
         default: cerr_evt = 1'b1;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pc_q    <= RESET_VECTOR;
         wr_ptr  <= '0;
         depth_q <= 4'd0;
         upd_q   <= 1'b0;
         ovf_q   <= 1'b0;
         unf_q   <= 1'b0;
         cerr_q  <= 1'b0;
      end else begin
         upd_q  <= bus.pc_increment;
         ovf_q  <= (ovf_q  & ~bus.clear_err) | (bus.pc_increment & ovf_evt);
         unf_q  <= (unf_q  & ~bus.clear_err) | (bus.pc_increment & unf_evt);
         cerr_q <= (cerr_q & ~bus.clear_err) | (bus.pc_increment & cerr_evt);
         if (bus.pc_increment) begin
            pc_q <= pc_nxt;
            if (push) begin
               wr_ptr <= wr_ptr + PTR_W'(1);
               if (!ras_full) begin
                  depth_q <= depth_q + 4'd1;
               end
            end else if (pop) begin
               wr_ptr  <= top_ptr;
               depth_q <= depth_q - 4'd1;
            end
         end
      end
   end

   // Entries are never cleared; depth_q alone decides which are reachable
   always_ff @(posedge clk) begin
      if (bus.pc_increment && push) begin
         ras_mem[wr_ptr] <= pc_inc;
      end
   end

   assign bus.pc         = pc_q;
   assign bus.pc_plus1   = pc_inc;
   assign bus.pc_updated = upd_q;
   assign bus.ras_depth  = depth_q;
   assign bus.ras_ovf    = ovf_q;
   assign bus.ras_unf    = unf_q;
   assign bus.ctrl_err   = cerr_q;
endmodule

// File: tb/tb_pc_unit.sv
// Directed scenarios with literal expectations plus random traffic, all checked
// each cycle against a queue-based reference model of the PC and return stack.
module tb_pc_unit;
   localparam logic [15:0] RV    = 16'h0000;
   localparam int          DEPTH = 4;

   logic clk = 1'b0;
   logic rst_n;
   pc_unit_if bus();

   pc_unit #(.RESET_VECTOR(RV), .RAS_DEPTH(DEPTH)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   logic [15:0] m_pc;
   logic [15:0] m_stack[$];
   logic        m_upd, m_ovf, m_unf, m_cerr;
   int          n_cmp = 0;
   int          n_bad = 0;
   bit          chk_en = 1'b0;

   task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_pc = RV;
      m_stack.delete();
      m_upd = 1'b0;
      m_ovf = 1'b0;
      m_unf = 1'b0;
      m_cerr = 1'b0;
   endtask

   task automatic model_step();
      logic nov, nun, nce;
      nov = 1'b0; nun = 1'b0; nce = 1'b0;
      m_upd = bus.pc_increment;
      if (bus.pc_increment) begin
         case (bus.pc_ctrl)
            3'd0: begin
               if (bus.is_call) begin
                  if (m_stack.size() == DEPTH) begin
                     m_stack.delete(0);
                     nov = 1'b1;
                  end
                  m_stack.push_back(m_pc + 16'd1);
               end
               m_pc = bus.jump_target;
            end
            3'd1: m_pc = m_pc + bus.branch_offset;
            3'd2: begin
               if (m_stack.size() == 0) begin
                  m_pc = m_pc + 16'd1;
                  nun = 1'b1;
               end else begin
                  m_pc = m_stack.pop_back();
               end
            end
            3'd3: m_pc = m_pc + 16'd1;
            3'd4: m_pc = bus.loop_target;
            default: begin
               m_pc = m_pc + 16'd1;
               nce = 1'b1;
            end
         endcase
      end
      if (bus.clear_err) begin
         m_ovf = 1'b0; m_unf = 1'b0; m_cerr = 1'b0;
      end
      m_ovf  = m_ovf | nov;
      m_unf  = m_unf | nun;
      m_cerr = m_cerr | nce;
   endtask

   initial begin
      forever begin
         @(posedge clk or negedge rst_n);
         if (!rst_n) model_reset();
         else model_step();
      end
   end

   initial begin
      forever begin
         @(negedge clk);
         if (chk_en && rst_n) begin
            chk("pc", bus.pc, m_pc);
            chk("pc_plus1", bus.pc_plus1, m_pc + 16'd1);
            chk("pc_updated", 16'(bus.pc_updated), 16'(m_upd));
            chk("ras_depth", 16'(bus.ras_depth), 16'(m_stack.size()));
            chk("ras_ovf", 16'(bus.ras_ovf), 16'(m_ovf));
            chk("ras_unf", 16'(bus.ras_unf), 16'(m_unf));
            chk("ctrl_err", 16'(bus.ctrl_err), 16'(m_cerr));
         end
      end
   end

   task automatic commit(input logic [2:0] c, input logic call, input logic [15:0] jt,
                         input logic [15:0] off, input logic [15:0] lt);
      bus.pc_ctrl = c;
      bus.is_call = call;
      bus.jump_target = jt;
      bus.branch_offset = off;
      bus.loop_target = lt;
      bus.clear_err = 1'b0;
      bus.pc_increment = 1'b1;
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic idle(input logic clr);
      bus.pc_increment = 1'b0;
      bus.clear_err = clr;
      @(posedge clk);
      @(negedge clk);
      bus.clear_err = 1'b0;
   endtask

   logic [15:0] ret_exp [4];

   initial begin
      rst_n = 1'b0;
      bus.pc_ctrl = 3'd3;
      bus.pc_increment = 1'b0;
      bus.is_call = 1'b0;
      bus.jump_target = 16'h0;
      bus.branch_offset = 16'h0;
      bus.loop_target = 16'h0;
      bus.clear_err = 1'b0;
      model_reset();
      repeat (3) @(negedge clk);
      chk("rst_pc", bus.pc, 16'h0000);
      chk("rst_depth", 16'(bus.ras_depth), 16'd0);
      chk("rst_upd", 16'(bus.pc_updated), 16'd0);
      chk("rst_flags", 16'({bus.ras_ovf, bus.ras_unf, bus.ctrl_err}), 16'd0);
      rst_n = 1'b1;
      chk_en = 1'b1;

      // sequential run
      for (int i = 1; i <= 3; i++) begin
         commit(3'd3, 1'b0, 16'h0, 16'h0, 16'h0);
         chk("seq_pc", bus.pc, 16'(i));
         chk("seq_upd", 16'(bus.pc_updated), 16'd1);
      end
      idle(1'b0);
      chk("idle_upd", 16'(bus.pc_updated), 16'd0);

      // branch wrap
      commit(3'd0, 1'b0, 16'h0002, 16'h0, 16'h0);
      commit(3'd1, 1'b0, 16'h0, 16'hFFFC, 16'h0);
      chk("br_wrap", bus.pc, 16'hFFFE);
      commit(3'd3, 1'b0, 16'h0, 16'h0, 16'h0);
      chk("seq_ffff", bus.pc, 16'hFFFF);
      commit(3'd3, 1'b0, 16'h0, 16'h0, 16'h0);
      chk("seq_wrap", bus.pc, 16'h0000);
      chk("seq_wrap_p1", bus.pc_plus1, 16'h0001);

      // nested call/return
      commit(3'd4, 1'b0, 16'h0, 16'h0, 16'd10);
      chk("loop_pc", bus.pc, 16'd10);
      commit(3'd0, 1'b1, 16'd100, 16'h0, 16'h0);
      chk("call1_pc", bus.pc, 16'd100);
      chk("call1_depth", 16'(bus.ras_depth), 16'd1);
      commit(3'd0, 1'b1, 16'd200, 16'h0, 16'h0);
      chk("call2_depth", 16'(bus.ras_depth), 16'd2);
      commit(3'd2, 1'b0, 16'h0, 16'h0, 16'h0);
      chk("ret1_pc", bus.pc, 16'd101);
      commit(3'd2, 1'b0, 16'h0, 16'h0, 16'h0);
      chk("ret2_pc", bus.pc, 16'd11);
      chk("ret2_depth", 16'(bus.ras_depth), 16'd0);

      // overflow then underflow
      for (int i = 1; i <= 5; i++) commit(3'd0, 1'b1, 16'(i * 16'h1000), 16'h0, 16'h0);
      chk("ovf_flag", 16'(bus.ras_ovf), 16'd1);
      chk("ovf_depth", 16'(bus.ras_depth), 16'd4);
      ret_exp[0] = 16'h4001; ret_exp[1] = 16'h3001; ret_exp[2] = 16'h2001; ret_exp[3] = 16'h1001;
      for (int i = 0; i < 4; i++) begin
         commit(3'd2, 1'b0, 16'h0, 16'h0, 16'h0);
         chk("ovf_ret", bus.pc, ret_exp[i]);
      end
      commit(3'd2, 1'b0, 16'h0, 16'h0, 16'h0);
      chk("unf_pc", bus.pc, 16'h1002);
      chk("unf_flag", 16'(bus.ras_unf), 16'd1);
      idle(1'b1);
      chk("clr_flags", 16'({bus.ras_ovf, bus.ras_unf}), 16'd0);

      // gating and illegal selects
      bus.pc_ctrl = 3'd0;
      bus.is_call = 1'b1;
      bus.jump_target = 16'hBEEF;
      repeat (5) @(negedge clk);
      chk("gate_pc", bus.pc, 16'h1002);
      commit(3'd6, 1'b1, 16'hBEEF, 16'h0, 16'h0);
      chk("ill_pc", bus.pc, 16'h1003);
      chk("ill_err", 16'(bus.ctrl_err), 16'd1);
      chk("ill_depth", 16'(bus.ras_depth), 16'd0);
      bus.pc_ctrl = 3'd7;
      bus.clear_err = 1'b1;
      @(posedge clk);
      @(negedge clk);
      chk("clr_same_edge", 16'(bus.ctrl_err), 16'd1);
      idle(1'b1);
      chk("clr_err", 16'(bus.ctrl_err), 16'd0);

      // async reset mid call sequence
      commit(3'd0, 1'b1, 16'h0500, 16'h0, 16'h0);
      commit(3'd0, 1'b1, 16'h0600, 16'h0, 16'h0);
      chk("pre_rst_depth", 16'(bus.ras_depth), 16'd2);
      #2 rst_n = 1'b0;
      #1;
      chk("arst_pc", bus.pc, RV);
      chk("arst_depth", 16'(bus.ras_depth), 16'd0);
      chk("arst_upd", 16'(bus.pc_updated), 16'd0);
      #1 rst_n = 1'b1;
      commit(3'd2, 1'b0, 16'h0, 16'h0, 16'h0);
      chk("post_rst_ret", bus.pc, 16'h0001);
      chk("post_rst_unf", 16'(bus.ras_unf), 16'd1);

      // random traffic
      for (int i = 0; i < 2000; i++) begin
         if (i % 500 == 250) begin
            #2 rst_n = 1'b0;
            #2 rst_n = 1'b1;
         end
         if ($urandom_range(0, 9) < 8) bus.pc_ctrl = 3'($urandom_range(0, 4));
         else bus.pc_ctrl = 3'($urandom_range(5, 7));
         bus.pc_increment = ($urandom_range(0, 3) != 0);
         bus.is_call = 1'($urandom_range(0, 1));
         bus.jump_target = 16'($urandom);
         bus.branch_offset = 16'($urandom);
         bus.loop_target = 16'($urandom);
         bus.clear_err = ($urandom_range(0, 15) == 0);
         @(posedge clk);
         @(negedge clk);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
